// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: forward source select and in-flight stage entry.
package fwd_pkg;

    // Stage entries carry a fixed-width destination; ADDR_W must not exceed this.
    localparam int unsigned DST_W_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic                 load;
        logic [DST_W_MAX-1:0] dst;
    } stage_ent_t;

    function automatic logic stageHit(stage_ent_t ent, logic [DST_W_MAX-1:0] addr);
        return ent.valid & ent.we & (ent.dst == addr);
    endfunction

endpackage

// File: rtl/fwd_port_mux.sv
// Per read-port compare against the EX/MEM/WB shadow stages and youngest-first operand select.
module fwd_port_mux
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rfData,
    input  stage_ent_t        exEnt,
    input  stage_ent_t        memEnt,
    input  stage_ent_t        wbEnt,
    input  logic [DATA_W-1:0] exResult,
    input  logic [DATA_W-1:0] memResult,
    input  logic [DATA_W-1:0] wbResult,
    output fwd_sel_e          sel,
    output logic [DATA_W-1:0] operand,
    output logic              loadHit
);

    logic [DST_W_MAX-1:0] addrExt;
    logic                 isZero;
    logic                 exHit;
    logic                 memHit;
    logic                 wbHit;
    logic                 unusedLoadBits;

    assign addrExt = DST_W_MAX'(rdAddr);
    assign isZero  = (ZERO_REG != 0) && (rdAddr == '0);
    assign exHit   = stageHit(exEnt, addrExt) & ~isZero;
    assign memHit  = stageHit(memEnt, addrExt) & ~isZero;
    assign wbHit   = stageHit(wbEnt, addrExt) & ~isZero;
    assign loadHit = exHit & exEnt.load;

    // MEM/WB results are always valid, so their load flag plays no part in the select.
    assign unusedLoadBits = memEnt.load | wbEnt.load;

    always_comb begin
        sel     = FWD_RF;
        operand = rfData;
        if (exHit && !exEnt.load) begin
            sel     = FWD_EX;
            operand = exResult;
        end else if (memHit) begin
            sel     = FWD_MEM;
            operand = memResult;
        end else if (wbHit) begin
            sel     = FWD_WB;
            operand = wbResult;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with EX/MEM/WB shadow stages.
// Optional stall statistics counter enabled by defining FWD_STALL_STATS_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic                     issue_load,
    input  logic [ADDR_W-1:0]        issue_dst,
    input  logic                     flush,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0] rd_data_rf,
    input  logic [DATA_W-1:0]        ex_result,
    input  logic [DATA_W-1:0]        mem_result,
    input  logic [DATA_W-1:0]        wb_result,
    output logic [NUM_RD*DATA_W-1:0] operand,
    output logic [NUM_RD*2-1:0]      fwd_sel,
    output logic                     stall,
    output logic                     wb_we
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    stage_ent_t       exQ;
    stage_ent_t       memQ;
    stage_ent_t       wbQ;
    stage_ent_t       exD;
    stage_ent_t       memD;
    stage_ent_t       issueEnt;
    logic [NUM_RD-1:0] loadHit;
    fwd_sel_e         selArr [NUM_RD];

    for (genvar i = 0; i < NUM_RD; i++) begin : gPort
        fwd_port_mux #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .ZERO_REG(ZERO_REG)
        ) uMux (
            .rdAddr   (rd_addr[i*ADDR_W +: ADDR_W]),
            .rfData   (rd_data_rf[i*DATA_W +: DATA_W]),
            .exEnt    (exQ),
            .memEnt   (memQ),
            .wbEnt    (wbQ),
            .exResult (ex_result),
            .memResult(mem_result),
            .wbResult (wb_result),
            .sel      (selArr[i]),
            .operand  (operand[i*DATA_W +: DATA_W]),
            .loadHit  (loadHit[i])
        );
        assign fwd_sel[i*2 +: 2] = selArr[i];
    end

    // A non-valid decode slot has no operands to wait for.
    assign stall = issue_valid & (|loadHit);
    assign wb_we = wbQ.valid & wbQ.we;

    always_comb begin
        issueEnt       = '0;
        issueEnt.valid = issue_valid;
        issueEnt.we    = issue_we;
        issueEnt.load  = issue_load;
        issueEnt.dst   = DST_W_MAX'(issue_dst);
        exD            = (flush || stall) ? '0 : issueEnt;
        memD           = flush ? '0 : exQ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exQ  <= '0;
            memQ <= '0;
            wbQ  <= '0;
        end else begin
            exQ  <= exD;
            memQ <= memD;
            wbQ  <= memQ;
        end
    end

`ifdef FWD_STALL_STATS_EN
    logic [15:0] stallCntQ;

    // Flushed stalls never turn into real wait cycles, so they are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ <= '0;
        end else if (stall && !flush && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign stall_cnt = stallCntQ;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit (ADDR_W=3, DATA_W=8, NUM_RD=2, ZERO_REG=1).
module tb_fwd_hazard_unit;

    localparam logic [7:0] EX_VAL  = 8'hA1;
    localparam logic [7:0] MEM_VAL = 8'hB2;
    localparam logic [7:0] WB_VAL  = 8'hC3;
    localparam logic [7:0] RF0_VAL = 8'h11;
    localparam logic [7:0] RF1_VAL = 8'h22;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_we;
    logic        issue_load;
    logic [2:0]  issue_dst;
    logic        flush;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data_rf;
    logic [7:0]  ex_result;
    logic [7:0]  mem_result;
    logic [7:0]  wb_result;
    logic [15:0] operand;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        wb_we;
`ifdef FWD_STALL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int nChecks = 0;
    int nErr    = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .ADDR_W  (3),
        .DATA_W  (8),
        .NUM_RD  (2),
        .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_we   (issue_we),
        .issue_load (issue_load),
        .issue_dst  (issue_dst),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_data_rf (rd_data_rf),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .wb_result  (wb_result),
        .operand    (operand),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .wb_we      (wb_we)
`ifdef FWD_STALL_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic       we;
        logic       ld;
        logic [2:0] dst;
        logic       fl;
        logic [2:0] a0;
        logic [2:0] a1;
        logic       c0;
        logic       c1;
        logic       eStall;
        logic [1:0] e0;
        logic [1:0] e1;
        logic       eWbWe;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic rst, iv, we, ld, input logic [2:0] dst, input logic fl,
                       input logic [2:0] a0, a1, input logic c0, c1, eStall,
                       input logic [1:0] e0, e1, input logic eWbWe);
        vec_t v;
        v.rst = rst; v.iv = iv; v.we = we; v.ld = ld; v.dst = dst; v.fl = fl;
        v.a0 = a0; v.a1 = a1; v.c0 = c0; v.c1 = c1;
        v.eStall = eStall; v.e0 = e0; v.e1 = e1; v.eWbWe = eWbWe;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expOperand(input logic [1:0] sel, input int port,
                                              input logic [7:0] memVal);
        case (sel)
            2'd1:    return EX_VAL;
            2'd2:    return memVal;
            2'd3:    return WB_VAL;
            default: return (port == 0) ? RF0_VAL : RF1_VAL;
        endcase
    endfunction

    task automatic idleInputs();
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_we    = 1'b0;
        issue_load  = 1'b0;
        issue_dst   = 3'd0;
        flush       = 1'b0;
        rd_addr     = 6'd0;
    endtask

    task automatic doReset();
        @(negedge clk);
        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Load r2 followed by a dependent read of r2; ends at the negedge after the op issues.
    task automatic doLoadUse();
        @(negedge clk);
        idleInputs();
        issue_valid = 1'b1; issue_we = 1'b1; issue_load = 1'b1; issue_dst = 3'd2;
        @(posedge clk);
        @(negedge clk);
        issue_load = 1'b0; issue_dst = 3'd1; rd_addr = {3'd0, 3'd2};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stalls;

        idleInputs();
        rd_data_rf = {RF1_VAL, RF0_VAL};
        ex_result  = EX_VAL;
        mem_result = MEM_VAL;
        wb_result  = WB_VAL;
        reset      = 1'b1;
        repeat (2) @(posedge clk);

        //  rst iv we ld dst fl  a0 a1 c0 c1 st e0 e1 wbwe
        add(0, 1, 1, 0, 3, 0,   3, 0, 1, 1, 0, 0, 0, 0);  // preload r3 writes
        add(0, 1, 1, 0, 3, 0,   3, 1, 1, 1, 0, 1, 0, 0);
        add(0, 1, 1, 0, 3, 0,   3, 1, 1, 1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0, 1, 0, 1);  // reset with all stages on r3
        add(0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 5, 0,   5, 5, 1, 1, 0, 0, 0, 0);  // priority on r5
        add(0, 1, 1, 0, 5, 0,   5, 0, 1, 1, 0, 1, 0, 0);
        add(0, 1, 1, 0, 5, 0,   5, 0, 1, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,   5, 5, 1, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0,   5, 0, 1, 1, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0,   5, 4, 1, 1, 0, 3, 0, 1);
        add(0, 1, 1, 1, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);  // zero register
        add(0, 1, 1, 0, 1, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 4, 0,   4, 0, 1, 1, 0, 0, 0, 0);  // flush during stall
        add(0, 1, 1, 0, 6, 1,   4, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,   4, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 4, 0,   0, 0, 1, 1, 0, 0, 0, 0);  // non-valid decode never stalls
        add(0, 0, 0, 0, 0, 0,   4, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   4, 0, 1, 1, 0, 2, 0, 0);
        add(0, 1, 1, 1, 2, 0,   0, 0, 1, 1, 0, 0, 0, 1);  // load-use on port 1
        add(0, 1, 1, 0, 7, 0,   1, 2, 1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 7, 0,   1, 2, 1, 1, 0, 0, 2, 0);
        add(0, 0, 0, 0, 0, 0,   7, 2, 1, 1, 0, 1, 3, 1);

        foreach (vecs[n]) begin
            @(negedge clk);
            reset       = vecs[n].rst;
            issue_valid = vecs[n].iv;
            issue_we    = vecs[n].we;
            issue_load  = vecs[n].ld;
            issue_dst   = vecs[n].dst;
            flush       = vecs[n].fl;
            rd_addr     = {vecs[n].a1, vecs[n].a0};
            #1;
            check($sformatf("v%0d stall", n), 16'(stall), 16'(vecs[n].eStall));
            check($sformatf("v%0d wb_we", n), 16'(wb_we), 16'(vecs[n].eWbWe));
            if (vecs[n].c0) begin
                check($sformatf("v%0d sel0", n), 16'(fwd_sel[1:0]), 16'(vecs[n].e0));
                check($sformatf("v%0d op0", n), 16'(operand[7:0]),
                      16'(expOperand(vecs[n].e0, 0, MEM_VAL)));
            end
            if (vecs[n].c1) begin
                check($sformatf("v%0d sel1", n), 16'(fwd_sel[3:2]), 16'(vecs[n].e1));
                check($sformatf("v%0d op1", n), 16'(operand[15:8]),
                      16'(expOperand(vecs[n].e1, 1, MEM_VAL)));
            end
        end

        // Load-use: exactly one stall, then the load result comes from MEM.
        doReset();
        issue_valid = 1'b1; issue_we = 1'b1; issue_load = 1'b1; issue_dst = 3'd2;
        @(posedge clk);
        @(negedge clk);
        issue_load = 1'b0; issue_dst = 3'd1; rd_addr = {3'd0, 3'd2};
        mem_result = 8'h5E;
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (!stall) break;
            stalls++;
            @(posedge clk);
            @(negedge clk);
        end
        check("loaduse stall cycles", 16'(stalls), 16'd1);
        check("loaduse sel", 16'(fwd_sel[1:0]), 16'd2);
        check("loaduse operand", 16'(operand[7:0]), 16'h005E);
        mem_result = MEM_VAL;

`ifdef FWD_STALL_STATS_EN
        doReset();
        check("stall_cnt reset", stall_cnt, 16'd0);
        for (int k = 0; k < 3; k++) doLoadUse();
        check("stall_cnt three", stall_cnt, 16'd3);
        @(negedge clk);
        force dut.stallCntQ = 16'hFFFE;
        #1;
        release dut.stallCntQ;
        for (int k = 0; k < 5; k++) doLoadUse();
        check("stall_cnt saturate", stall_cnt, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
